// File: rtl/ahb2apb_pkg.sv
// Shared types and constants for the AHB-to-APB bridge.
// Holds the controller state enum, HTRANS codes and the peripheral map.
package ahb2apb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WWAIT,
    ST_READ,
    ST_WRITE,
    ST_WRITEP,
    ST_RENABLE,
    ST_WENABLE,
    ST_WENABLEP
  } state_t;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [31:0] PERIPH0_BASE = 32'h8000_0000;
  localparam logic [31:0] PERIPH1_BASE = 32'h8400_0000;
  localparam logic [31:0] PERIPH2_BASE = 32'h8800_0000;
  localparam logic [31:0] PERIPH3_BASE = 32'h8C00_0000;

  // Which pipelined address/data/select the output bank loads.
  typedef enum logic [1:0] {
    LD_HOLD,
    LD_RD,
    LD_WR1,
    LD_WR2
  } ld_t;

  typedef struct packed {
    ld_t  ld;
    logic sel_clr;
    logic penable;
    logic hready;
  } out_ctl_t;

endpackage

// File: rtl/apb_controller_out_reg.sv
// Registered APB output bank with address/data/select load muxing.
// Also keeps the two-deep peripheral select history.
module apb_out_reg
  import ahb2apb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int NSLV   = 3
) (
  input  logic              Hclk,
  input  logic              Hreset,
  input  out_ctl_t          ctl,
  input  logic [NSLV-1:0]   temp_selx,
  input  logic [ADDR_W-1:0] Haddr,
  input  logic [ADDR_W-1:0] Haddr1,
  input  logic [ADDR_W-1:0] Haddr2,
  input  logic [DATA_W-1:0] Hwdata,
  input  logic [DATA_W-1:0] Hwdata1,
  output logic [NSLV-1:0]   Pselx,
  output logic              Penable,
  output logic              Pwrite,
  output logic [ADDR_W-1:0] Paddr,
  output logic [DATA_W-1:0] Pwdata,
  output logic              Hreadyout
);

  logic [NSLV-1:0] sel1;
  logic [NSLV-1:0] sel2;

  // Select history follows the address pipeline one and two cycles back.
  always_ff @(posedge Hclk) begin
    if (Hreset) begin
      sel1 <= '0;
      sel2 <= '0;
    end else begin
      sel1 <= temp_selx;
      sel2 <= sel1;
    end
  end

  // Output bank: load from the chosen pipeline tap or hold.
  always_ff @(posedge Hclk) begin
    if (Hreset) begin
      Pselx     <= '0;
      Penable   <= 1'b0;
      Pwrite    <= 1'b0;
      Paddr     <= '0;
      Pwdata    <= '0;
      Hreadyout <= 1'b1;
    end else begin
      Penable   <= ctl.penable;
      Hreadyout <= ctl.hready;
      unique case (ctl.ld)
        LD_RD: begin
          Paddr  <= Haddr;
          Pselx  <= temp_selx;
          Pwrite <= 1'b0;
        end
        LD_WR1: begin
          Paddr  <= Haddr1;
          Pselx  <= sel1;
          Pwdata <= Hwdata;
          Pwrite <= 1'b1;
        end
        LD_WR2: begin
          Paddr  <= Haddr2;
          Pselx  <= sel2;
          Pwdata <= Hwdata1;
          Pwrite <= 1'b1;
        end
        default: begin
          if (ctl.sel_clr) Pselx <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/apb_controller.sv
// APB setup/enable sequencer of the AHB-to-APB bridge.
// Optional APB_WAIT_STATE_EN adds Pready-driven wait states.
module apb_controller
  import ahb2apb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int NSLV   = 3
) (
  input  logic              Hclk,
  input  logic              Hreset,
  input  logic              valid,
  input  logic              Hwrite,
  input  logic              Hwritereg,
  input  logic [ADDR_W-1:0] Haddr,
  input  logic [ADDR_W-1:0] Haddr1,
  input  logic [ADDR_W-1:0] Haddr2,
  input  logic [DATA_W-1:0] Hwdata,
  input  logic [DATA_W-1:0] Hwdata1,
  input  logic [NSLV-1:0]   temp_selx,
  output logic [NSLV-1:0]   Pselx,
  output logic              Penable,
  output logic              Pwrite,
  output logic [ADDR_W-1:0] Paddr,
  output logic [DATA_W-1:0] Pwdata,
  output logic              Hreadyout
`ifdef APB_WAIT_STATE_EN
  ,
  input  logic              Pready
`endif
);

  state_t   st;
  state_t   nxt;
  out_ctl_t ctl;
  logic     hold;

  // State register.
  always_ff @(posedge Hclk) begin
    if (Hreset) st <= ST_IDLE;
    else        st <= nxt;
  end

  // Next state and the output-bank load derived from it.
  always_comb begin
    nxt  = st;
    hold = 1'b0;
    ctl  = '{ld: LD_HOLD, sel_clr: 1'b0,
             penable: 1'b0, hready: 1'b1};
    unique case (st)
      ST_IDLE: begin
        if (valid) nxt = Hwrite ? ST_WWAIT : ST_READ;
      end
      ST_WWAIT:  nxt = valid ? ST_WRITEP : ST_WRITE;
      ST_READ:   nxt = ST_RENABLE;
      ST_RENABLE, ST_WENABLE: begin
        if (!valid)      nxt = ST_IDLE;
        else if (Hwrite) nxt = ST_WWAIT;
        else             nxt = ST_READ;
      end
      ST_WRITE:  nxt = valid ? ST_WENABLEP : ST_WENABLE;
      ST_WRITEP: nxt = ST_WENABLEP;
      ST_WENABLEP: begin
        if (!Hwritereg) nxt = ST_READ;
        else if (valid) nxt = ST_WRITEP;
        else            nxt = ST_WRITE;
      end
      default:   nxt = ST_IDLE;
    endcase
`ifdef APB_WAIT_STATE_EN
    hold = !Pready && (st == ST_RENABLE ||
                       st == ST_WENABLE ||
                       st == ST_WENABLEP);
`endif
    unique case (nxt)
      ST_IDLE, ST_WWAIT: ctl.sel_clr = 1'b1;
      ST_READ: begin
        ctl.ld     = LD_RD;
        ctl.hready = 1'b0;
      end
      ST_WRITE, ST_WRITEP: begin
        ctl.ld     = (st == ST_WENABLEP) ? LD_WR2 : LD_WR1;
        ctl.hready = 1'b0;
      end
      default: ctl.penable = 1'b1;
    endcase
    if (hold) begin
      nxt = st;
      ctl = '{ld: LD_HOLD, sel_clr: 1'b0,
              penable: 1'b1, hready: 1'b0};
    end
  end

  apb_out_reg #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .NSLV   (NSLV)
  ) u_out (
    .Hclk      (Hclk),
    .Hreset    (Hreset),
    .ctl       (ctl),
    .temp_selx (temp_selx),
    .Haddr     (Haddr),
    .Haddr1    (Haddr1),
    .Haddr2    (Haddr2),
    .Hwdata    (Hwdata),
    .Hwdata1   (Hwdata1),
    .Pselx     (Pselx),
    .Penable   (Penable),
    .Pwrite    (Pwrite),
    .Paddr     (Paddr),
    .Pwdata    (Pwdata),
    .Hreadyout (Hreadyout)
  );

endmodule

// File: tb/tb_apb_controller.sv
// Bench for apb_controller: directed AHB scenarios plus random traffic.
// A transaction-level reference model predicts every registered output.
module tb_apb_controller;

  logic        Hclk = 1'b0;
  logic        Hreset;
  logic        valid;
  logic        Hwrite;
  logic        Hwritereg = 1'b0;
  logic [1:0]  Htrans;
  logic [31:0] Haddr;
  logic [31:0] Haddr1 = '0;
  logic [31:0] Haddr2 = '0;
  logic [31:0] Hwdata;
  logic [31:0] Hwdata1 = '0;
  logic [2:0]  temp_selx;
  logic [2:0]  Pselx;
  logic        Penable;
  logic        Pwrite;
  logic [31:0] Paddr;
  logic [31:0] Pwdata;
  logic        Hreadyout;
`ifdef APB_WAIT_STATE_EN
  logic        Pready = 1'b1;
`endif

  int n_vec = 0;
  int n_err = 0;

  string       m_st;
  logic [2:0]  m_psel, m_sel1, m_sel2;
  logic        m_pen, m_pwr, m_rdy;
  logic [31:0] m_paddr, m_pwdata;

  always #5 Hclk = ~Hclk;

  apb_controller #(
    .ADDR_W (32),
    .DATA_W (32),
    .NSLV   (3)
  ) dut (
    .Hclk      (Hclk),
    .Hreset    (Hreset),
    .valid     (valid),
    .Hwrite    (Hwrite),
    .Hwritereg (Hwritereg),
    .Haddr     (Haddr),
    .Haddr1    (Haddr1),
    .Haddr2    (Haddr2),
    .Hwdata    (Hwdata),
    .Hwdata1   (Hwdata1),
    .temp_selx (temp_selx),
    .Pselx     (Pselx),
    .Penable   (Penable),
    .Pwrite    (Pwrite),
    .Paddr     (Paddr),
    .Pwdata    (Pwdata),
    .Hreadyout (Hreadyout)
`ifdef APB_WAIT_STATE_EN
    ,
    .Pready    (Pready)
`endif
  );

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h",
               tag, $time, got, exp);
    end
  endtask

  function automatic logic [2:0] dec(input logic [31:0] a);
    logic [5:0] top;
    top = a[31:26];
    if (top == 6'b100000)      return 3'b001;
    else if (top == 6'b100001) return 3'b010;
    else if (top == 6'b100010) return 3'b100;
    else                       return 3'b000;
  endfunction

  task automatic drive(input logic [1:0] tr, input logic w,
                       input logic [31:0] a, input logic [31:0] d);
    Htrans    = tr;
    Hwrite    = w;
    Haddr     = a;
    Hwdata    = d;
    temp_selx = dec(a);
    valid     = tr[1] && (dec(a) != 3'b000);
  endtask

  function automatic bit is_en(input string s);
    return s == "RENABLE" || s == "WENABLE" || s == "WENABLEP";
  endfunction

  // Advance the reference by one edge using the inputs now applied.
  task automatic model_step();
    string nx;
    bit    stall;
    if (Hreset) begin
      m_st = "IDLE";
      m_psel = 0; m_pen = 0; m_pwr = 0; m_rdy = 1;
      m_paddr = 0; m_pwdata = 0; m_sel1 = 0; m_sel2 = 0;
      return;
    end
    if (m_st == "IDLE")
      nx = !valid ? "IDLE" : (Hwrite ? "WWAIT" : "READ");
    else if (m_st == "WWAIT")
      nx = valid ? "WRITEP" : "WRITE";
    else if (m_st == "READ")
      nx = "RENABLE";
    else if (m_st == "WRITE")
      nx = valid ? "WENABLEP" : "WENABLE";
    else if (m_st == "WRITEP")
      nx = "WENABLEP";
    else if (m_st == "WENABLEP")
      nx = !Hwritereg ? "READ" : (valid ? "WRITEP" : "WRITE");
    else
      nx = !valid ? "IDLE" : (Hwrite ? "WWAIT" : "READ");
    stall = 0;
`ifdef APB_WAIT_STATE_EN
    stall = is_en(m_st) && !Pready;
`endif
    if (stall) begin
      nx = m_st;
      m_rdy = 0;
    end else if (nx == "IDLE" || nx == "WWAIT") begin
      m_psel = 0; m_pen = 0; m_rdy = 1;
    end else if (nx == "READ") begin
      m_paddr = Haddr; m_psel = temp_selx;
      m_pwr = 0; m_pen = 0; m_rdy = 0;
    end else if (nx == "WRITE" || nx == "WRITEP") begin
      if (m_st == "WENABLEP") begin
        m_paddr = Haddr2; m_psel = m_sel2; m_pwdata = Hwdata1;
      end else begin
        m_paddr = Haddr1; m_psel = m_sel1; m_pwdata = Hwdata;
      end
      m_pwr = 1; m_pen = 0; m_rdy = 0;
    end else begin
      m_pen = 1; m_rdy = 1;
    end
    m_sel2 = m_sel1;
    m_sel1 = temp_selx;
    m_st   = nx;
  endtask

  task automatic cyc();
    model_step();
    @(posedge Hclk);
    #1;
    chk("Pselx", Pselx, m_psel);
    chk("Penable", Penable, m_pen);
    chk("Pwrite", Pwrite, m_pwr);
    chk("Paddr", Paddr, m_paddr);
    chk("Pwdata", Pwdata, m_pwdata);
    chk("Hreadyout", Hreadyout, m_rdy);
    chk("onehot", $onehot0(Pselx), 1);
    Haddr2    = Haddr1;
    Haddr1    = Haddr;
    Hwdata1   = Hwdata;
    Hwritereg = Hwrite;
  endtask

  localparam logic [1:0] NSQ = 2'b10;
  localparam logic [1:0] IDL = 2'b00;

  initial begin
    Hreset = 1'b1;
    drive(IDL, 0, 32'h0, 32'h0);
    m_st = "IDLE";
    cyc();
    cyc();
    chk("rst_ready", Hreadyout, 1);
    chk("rst_psel", Pselx, 0);
    Hreset = 1'b0;

    // Single write
    drive(NSQ, 1, 32'h8000_0010, 32'h0);
    cyc();
    chk("w_wait_psel", Pselx, 0);
    drive(IDL, 0, 32'h0, 32'hDEAD_BEEF);
    cyc();
    chk("w_paddr", Paddr, 32'h8000_0010);
    chk("w_psel", Pselx, 3'b001);
    chk("w_pwdata", Pwdata, 32'hDEAD_BEEF);
    chk("w_pwrite", Pwrite, 1);
    chk("w_setup_pen", Penable, 0);
    cyc();
    chk("w_enable", Penable, 1);
    cyc();
    chk("w_idle_psel", Pselx, 0);

    // Single read
    drive(NSQ, 0, 32'h8400_0004, 32'h0);
    cyc();
    chk("r_psel", Pselx, 3'b010);
    chk("r_pen", Penable, 0);
    chk("r_ready", Hreadyout, 0);
    drive(IDL, 0, 32'h0, 32'h0);
    cyc();
    chk("r_enable", Penable, 1);
    chk("r_ready2", Hreadyout, 1);
    cyc();

    // Back-to-back writes
    drive(NSQ, 1, 32'h8800_0000, 32'h0);
    cyc();
    drive(NSQ, 1, 32'h8800_0004, 32'h1111_0000);
    cyc();
    chk("bb1_paddr", Paddr, 32'h8800_0000);
    chk("bb1_pwdata", Pwdata, 32'h1111_0000);
    chk("bb1_psel", Pselx, 3'b100);
    drive(IDL, 1, 32'h0, 32'h2222_0000);
    cyc();
    chk("bb1_enable", Penable, 1);
    drive(IDL, 0, 32'h0, 32'h0);
    cyc();
    chk("bb2_paddr", Paddr, 32'h8800_0004);
    chk("bb2_pwdata", Pwdata, 32'h2222_0000);
    chk("bb2_psel", Pselx, 3'b100);
    chk("bb2_setup", Penable, 0);
    cyc();
    chk("bb2_enable", Penable, 1);
    cyc();

    // Write followed by read
    drive(NSQ, 1, 32'h8000_0020, 32'h0);
    cyc();
    drive(NSQ, 0, 32'h8400_0008, 32'hCAFE_0001);
    cyc();
    chk("wr_pwdata", Pwdata, 32'hCAFE_0001);
    chk("wr_pwrite", Pwrite, 1);
    cyc();
    cyc();
    chk("wr_rd_pwrite", Pwrite, 0);
    chk("wr_rd_paddr", Paddr, 32'h8400_0008);
    chk("wr_rd_psel", Pselx, 3'b010);
    drive(IDL, 0, 32'h0, 32'h0);
    cyc();
    cyc();

    // Reset during a write setup cycle
    drive(NSQ, 1, 32'h8000_0040, 32'h0);
    cyc();
    drive(IDL, 0, 32'h0, 32'h5555_AAAA);
    cyc();
    chk("mr_setup", Pwrite, 1);
    Hreset = 1'b1;
    cyc();
    Hreset = 1'b0;
    chk("mr_psel", Pselx, 0);
    chk("mr_pen", Penable, 0);
    chk("mr_paddr", Paddr, 0);
    chk("mr_pwdata", Pwdata, 0);
    chk("mr_ready", Hreadyout, 1);

    // Out-of-range and IDLE requests
    for (int i = 0; i < 10; i++) begin
      if (i < 5) drive(IDL, 0, 32'h9000_0000, 32'h0);
      else       drive(IDL, 1, 32'h8000_0000, 32'h0);
      cyc();
      chk("idle_psel", Pselx, 0);
    end

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      logic [31:0] a;
      logic [1:0]  tr;
      a  = {6'b100000 + 6'($urandom_range(0, 4)),
            26'($urandom) & 26'h3FF_FFFC};
      tr = 2'($urandom);
      Hreset = ($urandom_range(0, 59) == 0);
`ifdef APB_WAIT_STATE_EN
      Pready = ($urandom_range(0, 3) != 0);
`endif
      drive(tr, 1'($urandom), a, $urandom);
      cyc();
    end
    Hreset = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
